// File: rtl/round_sequencer.sv
// Reaction-game round controller. Owns the shared timer: arms it with the
// response window at the latched difficulty, waits for a hit or a timeout,
// records the outcome, then runs an easy-rate gap before the next round.
module round_sequencer #(
  parameter int          NUM_ROUNDS = 8,
  parameter logic [11:0] ROUND_MS   = 12'd1000,
  parameter logic [11:0] GAP_MS     = 12'd500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  difficulty_sel,
  input  logic        hit,
  input  logic [11:0] timer_value,
  input  logic        timer_end_reached,
  output logic        timer_reset,
  output logic        timer_enable,
  output logic [1:0]  timer_difficulty,
  output logic [11:0] timer_end_value,
  output logic        round_active,
  output logic [3:0]  round_num,
  output logic [7:0]  score,
  output logic [7:0]  misses,
  output logic [11:0] last_reaction,
  output logic        game_over
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, GAP_ARM, GAP, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t      state, state_nx;
  logic [1:0]  diff_q;
  logic        first_q;     // first cycle of RUN/GAP: timer end flag may be stale
  logic [3:0]  round_inc;
  logic        timeout;

  assign round_inc = round_num + 4'd1;
  assign timeout   = timer_end_reached && !first_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and timer control decode
  always_comb begin
    state_nx         = state;
    timer_reset      = 1'b0;
    timer_enable     = 1'b0;
    timer_difficulty = 2'd0;
    timer_end_value  = 12'd0;
    case (state)
      IDLE: begin
        timer_reset = 1'b1;
        if (start) state_nx = ARM;
      end
      ARM: begin
        timer_reset      = 1'b1;
        timer_enable     = 1'b1;
        timer_end_value  = ROUND_MS;
        timer_difficulty = diff_q;
        state_nx         = RUN;
      end
      RUN: begin
        timer_enable     = 1'b1;
        timer_end_value  = ROUND_MS;
        timer_difficulty = diff_q;
        if (hit || timeout) state_nx = GAP_ARM;
      end
      GAP_ARM: begin
        timer_reset     = 1'b1;
        timer_enable    = 1'b1;
        timer_end_value = GAP_MS;
        state_nx        = (round_inc == LAST_ROUND) ? DONE : GAP;
      end
      GAP: begin
        timer_enable    = 1'b1;
        timer_end_value = GAP_MS;
        if (timeout) state_nx = ARM;
      end
      DONE: begin
        timer_reset = 1'b1;
        if (start) state_nx = ARM;
      end
      default: state_nx = IDLE;
    endcase
    // Reset overrides everything so the timer is held cleared immediately.
    if (reset) begin
      timer_reset      = 1'b1;
      timer_enable     = 1'b0;
      timer_difficulty = 2'd0;
      timer_end_value  = 12'd0;
    end
  end

  // Registered status, counters and latched difficulty
  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q        <= 2'd0;
      first_q       <= 1'b0;
      round_active  <= 1'b0;
      game_over     <= 1'b0;
      round_num     <= 4'd0;
      score         <= 8'd0;
      misses        <= 8'd0;
      last_reaction <= 12'd0;
    end else begin
      first_q      <= (state == ARM) || (state == GAP_ARM);
      round_active <= (state_nx == RUN);
      game_over    <= (state_nx == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            diff_q        <= (difficulty_sel == 2'd3) ? 2'd2 : difficulty_sel;
            round_num     <= 4'd0;
            score         <= 8'd0;
            misses        <= 8'd0;
            last_reaction <= 12'd0;
          end
        end
        RUN: begin
          // A hit in the same cycle as the end flag counts as a hit only.
          if (hit) begin
            if (score != 8'hFF) score <= score + 8'd1;
            last_reaction <= timer_value;
          end else if (timeout) begin
            if (misses != 8'hFF) misses <= misses + 8'd1;
          end
        end
        GAP_ARM: begin
          if (round_num != LAST_ROUND) round_num <= round_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-round controller that owns and configures the shared `timer` instance.
- Sequences a fixed number of reaction rounds. For each round it:
  - arms the timer with the round window at the selected difficulty;
  - waits for a player hit or a timeout;
  - records the result;
  - arms the timer again for an inter-round gap at easy rate.
- Sits between the game input logic (start/hit) and the timer, and feeds score and status to the display logic.

Parameters:
- NUM_ROUNDS, 8, rounds per game (1..15).
- ROUND_MS, 12'd1000, timer end_value for the response window.
- GAP_MS, 12'd500, timer end_value for the inter-round gap.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a game from IDLE or DONE.
- difficulty_sel  in  2  requested difficulty: 0 easy, 1 medium, 2 hard, 3 treated as 2.
- hit  in  1  single-cycle player-hit pulse.
- timer_value  in  12  current count from the timer.
- timer_end_reached  in  1  end flag from the timer.
- timer_reset  out  1  drives the timer's reset.
- timer_enable  out  1  drives the timer's enable.
- timer_difficulty  out  2  drives the timer's difficulty input.
- timer_end_value  out  12  drives the timer's end_value input.
- round_active  out  1  high while in RUN.
- round_num  out  4  number of completed rounds.
- score  out  8  hits this game; saturates at 255.
- misses  out  8  timeouts this game; saturates at 255.
- last_reaction  out  12  timer_value captured at the most recent hit.
- game_over  out  1  high in DONE.

Behaviour:
- State machine states: IDLE, ARM, RUN, GAP_ARM, GAP, DONE.
- All outputs are registered except the timer_* controls, which decode combinationally from the state and latched difficulty.

Reset:
- State goes to IDLE.
- round_active, round_num, score, misses, last_reaction, game_over and the latched difficulty all clear to 0.
- timer_reset=1 while reset is high; timer_enable=0.
- Reset mid-game aborts immediately with no partial update.

IDLE:
- timer_enable=0.
- On start: latch difficulty (3 becomes 2), clear score, misses, round_num and last_reaction, then go to ARM.

ARM (exactly 1 cycle):
- timer_reset=1, timer_enable=1.
- timer_end_value=ROUND_MS; timer_difficulty=latched value.
- Next state: RUN.

RUN:
- round_active=1, timer_enable=1, same end_value and difficulty as ARM.
- timer_end_reached is ignored in the first RUN cycle (stale-flag guard); hit is honoured in every RUN cycle, including the first.
- hit=1: score++, last_reaction<=timer_value, go to GAP_ARM.
- Otherwise, timer_end_reached=1 (after the first cycle): misses++, go to GAP_ARM.
- hit and timer_end_reached in the same cycle: the hit wins, and misses is unchanged.

GAP_ARM (exactly 1 cycle):
- round_num++.
- timer_reset=1, timer_enable=1, timer_end_value=GAP_MS, timer_difficulty=0.
- If the incremented round_num==NUM_ROUNDS, go to DONE; otherwise go to GAP.

GAP:
- timer_enable=1, end_value GAP_MS, difficulty 0.
- The first-cycle end flag is ignored.
- timer_end_reached: go to ARM.

DONE:
- game_over=1, timer_enable=0; score, misses, round_num and last_reaction hold their values.
- On start: behave as the IDLE start (clear and relatch), game_over drops, go to ARM.

Input qualification:
- hit is ignored in every state except RUN.
- start is ignored in ARM, RUN, GAP_ARM and GAP.
- difficulty_sel changes after start have no effect until the next start.

Arithmetic:
- score and misses saturate at 255 and never wrap.
- round_num never exceeds NUM_ROUNDS.

Timing:
- Round window in ms = ROUND_MS / (difficulty+1) under the timer's scaling.
- Gap is always GAP_MS ms.

Test Plan:
- Bench instantiates the real `timer`; sim params are NUM_ROUNDS=3, ROUND_MS=10, GAP_MS=5.
- Easy, no hits, start pulse -> 3 rounds of ~10 ms RUN with ~5 ms gaps; end state misses=3, score=0, round_num=3, game_over=1; round_active high exactly 3 times.
- Medium, hit 2 ms into every RUN -> score=3, misses=0; last_reaction≈4 (2x rate); each RUN ends 1 cycle after the hit.
- Hard (difficulty_sel=3 -> 2), no hits -> each RUN ≈3.3 ms, timer_difficulty=2 during RUN and 0 during GAP; gaps ≈5 ms.
- Hit pulses in IDLE, GAP and DONE, plus a hit coincident with timer_end_reached in RUN -> only the coincident hit counts: score=1, misses unchanged for that round.
- Reset asserted mid-RUN of round 2 -> next cycle: state IDLE, all outputs 0, timer_reset=1; start afterwards runs a clean 3-round game.
- Restart from DONE with start and a new difficulty_sel=1 -> counters clear, game_over drops, timer_difficulty=1 in the first RUN.
